// File: rtl/bp_fe_bht_updater.sv
// In-order update queue feeding the BHT write port; escalates to a forced write
// when the head record keeps getting rejected or the queue fills.
module bp_fe_bht_updater #(
    parameter int bht_idx_width_p    = 9,
    parameter int bht_offset_width_p = 3,
    parameter int ghist_width_p      = 2,
    parameter int bht_row_width_p    = 16,
    parameter int els_p              = 4,
    parameter int retry_limit_p      = 3
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          init_done_i,

    input  logic                          resolve_v_i,
    output logic                          resolve_ready_o,
    input  logic [bht_idx_width_p-1:0]    resolve_idx_i,
    input  logic [bht_offset_width_p-1:0] resolve_offset_i,
    input  logic [ghist_width_p-1:0]      resolve_ghist_i,
    input  logic [bht_row_width_p-1:0]    resolve_val_i,
    input  logic                          resolve_correct_i,

    output logic                          w_v_o,
    output logic                          w_force_o,
    output logic [bht_idx_width_p-1:0]    w_idx_o,
    output logic [bht_offset_width_p-1:0] w_offset_o,
    output logic [ghist_width_p-1:0]      w_ghist_o,
    output logic [bht_row_width_p-1:0]    w_val_o,
    output logic                          w_correct_o,
    input  logic                          w_yumi_i,

    output logic                          full_o
);

    localparam int ptr_w_lp   = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp   = $clog2(els_p + 1);
    localparam int retry_w_lp = $clog2(retry_limit_p + 1);
    localparam int rec_w_lp   = bht_idx_width_p + bht_offset_width_p
                              + ghist_width_p + bht_row_width_p + 1;

    logic [rec_w_lp-1:0]   mem_q [els_p];
    logic [ptr_w_lp-1:0]   wptr_q, wptr_d;
    logic [ptr_w_lp-1:0]   rptr_q, rptr_d;
    logic [cnt_w_lp-1:0]   cnt_q, cnt_d;
    logic [retry_w_lp-1:0] retry_q, retry_d;

    logic full, empty, enq, deq, retry_sat;

    assign full      = (cnt_q == cnt_w_lp'(els_p));
    assign empty     = (cnt_q == '0);
    assign retry_sat = (retry_q == retry_w_lp'(retry_limit_p));

    // No pass-through when full: a same-cycle dequeue does not free a slot early.
    assign resolve_ready_o = ~full;
    assign enq             = resolve_v_i & ~full;
    assign deq             = w_yumi_i & w_v_o;

    assign w_v_o     = init_done_i & ~empty;
    assign w_force_o = w_v_o & (retry_sat | full);
    assign full_o    = full;

    assign {w_idx_o, w_offset_o, w_ghist_o, w_val_o, w_correct_o} = mem_q[rptr_q];

    always_comb begin
        wptr_d  = wptr_q + ptr_w_lp'(enq);
        rptr_d  = rptr_q + ptr_w_lp'(deq);
        cnt_d   = cnt_q;
        retry_d = retry_q;
        case ({enq, deq})
            2'b10:   cnt_d = cnt_q + cnt_w_lp'(1);
            2'b01:   cnt_d = cnt_q - cnt_w_lp'(1);
            default: cnt_d = cnt_q;
        endcase
        // Retry count belongs to the head record; it restarts for each new head.
        if (deq)
            retry_d = '0;
        else if (w_v_o && !retry_sat)
            retry_d = retry_q + retry_w_lp'(1);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            retry_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq)
            mem_q[wptr_q] <= {resolve_idx_i, resolve_offset_i, resolve_ghist_i,
                              resolve_val_i, resolve_correct_i};
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i)
            assert (!(w_yumi_i && !w_v_o)) else $error("w_yumi_i asserted without w_v_o");
    end
`endif

endmodule

// File: tb/tb_bp_fe_bht_updater.sv
// Directed bench for bp_fe_bht_updater: init gating, fill, escalation, streaming, wrap, reset.
module tb_bp_fe_bht_updater;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        init_done_i;
    logic        resolve_v_i;
    logic        resolve_ready_o;
    logic [8:0]  resolve_idx_i;
    logic [2:0]  resolve_offset_i;
    logic [1:0]  resolve_ghist_i;
    logic [15:0] resolve_val_i;
    logic        resolve_correct_i;
    logic        w_v_o;
    logic        w_force_o;
    logic [8:0]  w_idx_o;
    logic [2:0]  w_offset_o;
    logic [1:0]  w_ghist_o;
    logic [15:0] w_val_o;
    logic        w_correct_o;
    logic        w_yumi_i;
    logic        full_o;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [8:0] exp_q [$];

    bp_fe_bht_updater dut (
        .clk_i(clk_i), .reset_i(reset_i), .init_done_i(init_done_i),
        .resolve_v_i(resolve_v_i), .resolve_ready_o(resolve_ready_o),
        .resolve_idx_i(resolve_idx_i), .resolve_offset_i(resolve_offset_i),
        .resolve_ghist_i(resolve_ghist_i), .resolve_val_i(resolve_val_i),
        .resolve_correct_i(resolve_correct_i),
        .w_v_o(w_v_o), .w_force_o(w_force_o), .w_idx_o(w_idx_o),
        .w_offset_o(w_offset_o), .w_ghist_o(w_ghist_o), .w_val_o(w_val_o),
        .w_correct_o(w_correct_o), .w_yumi_i(w_yumi_i), .full_o(full_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_rec(input logic v, input logic [8:0] idx);
        resolve_v_i       = v;
        resolve_idx_i     = idx;
        resolve_offset_i  = idx[2:0];
        resolve_ghist_i   = idx[3:2];
        resolve_val_i     = {idx[7:0], ~idx[7:0]};
        resolve_correct_i = idx[0];
    endtask

    task automatic test_reset();
        reset_i = 1'b1; init_done_i = 1'b0; w_yumi_i = 1'b0;
        set_rec(1'b0, 9'h0);
        step(); step();
        reset_i = 1'b0;
        #1;
        total_cnt++; if (resolve_ready_o !== 1'b1) $display("FAIL reset_ready got %b want 1", resolve_ready_o); else pass_cnt++;
        total_cnt++; if (w_v_o !== 1'b0) $display("FAIL reset_w_v got %b want 0", w_v_o); else pass_cnt++;
        total_cnt++; if (w_force_o !== 1'b0) $display("FAIL reset_force got %b want 0", w_force_o); else pass_cnt++;
        total_cnt++; if (full_o !== 1'b0) $display("FAIL reset_full got %b want 0", full_o); else pass_cnt++;
    endtask

    task automatic test_wait_init();
        init_done_i = 1'b0;
        set_rec(1'b1, 9'h011);
        #1;
        total_cnt++; if (resolve_ready_o !== 1'b1) $display("FAIL winit_ready0 got %b want 1", resolve_ready_o); else pass_cnt++;
        step();
        set_rec(1'b1, 9'h022);
        #1;
        total_cnt++; if (w_v_o !== 1'b0) $display("FAIL winit_w_v1 got %b want 0", w_v_o); else pass_cnt++;
        step();
        set_rec(1'b0, 9'h0);
        #1;
        total_cnt++; if (w_v_o !== 1'b0) $display("FAIL winit_w_v2 got %b want 0", w_v_o); else pass_cnt++;
        total_cnt++; if (resolve_ready_o !== 1'b1) $display("FAIL winit_ready2 got %b want 1", resolve_ready_o); else pass_cnt++;
        init_done_i = 1'b1; w_yumi_i = 1'b1;
        #1;
        total_cnt++; if (w_v_o !== 1'b1 || w_idx_o !== 9'h011) $display("FAIL winit_rec1 got v=%b idx=%h want v=1 idx=011", w_v_o, w_idx_o); else pass_cnt++;
        total_cnt++; if (w_val_o !== 16'h11ee) $display("FAIL winit_rec1_val got %h want 11ee", w_val_o); else pass_cnt++;
        step();
        total_cnt++; if (w_v_o !== 1'b1 || w_idx_o !== 9'h022) $display("FAIL winit_rec2 got v=%b idx=%h want v=1 idx=022", w_v_o, w_idx_o); else pass_cnt++;
        step();
        w_yumi_i = 1'b0;
        #1;
        total_cnt++; if (w_v_o !== 1'b0) $display("FAIL winit_empty got %b want 0", w_v_o); else pass_cnt++;
    endtask

    task automatic test_full();
        init_done_i = 1'b1; w_yumi_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_rec(1'b1, 9'(9'h030 + i));
            step();
        end
        set_rec(1'b0, 9'h0);
        #1;
        total_cnt++; if (full_o !== 1'b1) $display("FAIL full_flag got %b want 1", full_o); else pass_cnt++;
        total_cnt++; if (resolve_ready_o !== 1'b0) $display("FAIL full_ready got %b want 0", resolve_ready_o); else pass_cnt++;
        total_cnt++; if (w_force_o !== 1'b1) $display("FAIL full_force got %b want 1", w_force_o); else pass_cnt++;
        total_cnt++; if (w_idx_o !== 9'h030) $display("FAIL full_head got %h want 030", w_idx_o); else pass_cnt++;
        set_rec(1'b1, 9'h099);
        w_yumi_i = 1'b1;
        step();
        set_rec(1'b0, 9'h0);
        w_yumi_i = 1'b0;
        #1;
        total_cnt++; if (resolve_ready_o !== 1'b1) $display("FAIL full_ready_after got %b want 1", resolve_ready_o); else pass_cnt++;
        total_cnt++; if (full_o !== 1'b0) $display("FAIL full_flag_after got %b want 0", full_o); else pass_cnt++;
        w_yumi_i = 1'b1;
        for (int i = 1; i < 4; i++) begin
            #1;
            total_cnt++; if (w_v_o !== 1'b1 || w_idx_o !== 9'(9'h030 + i)) $display("FAIL full_drain%0d got v=%b idx=%h want v=1 idx=%h", i, w_v_o, w_idx_o, 9'(9'h030 + i)); else pass_cnt++;
            step();
        end
        w_yumi_i = 1'b0;
        #1;
        total_cnt++; if (w_v_o !== 1'b0) $display("FAIL full_no_5th got v=%b idx=%h want v=0", w_v_o, w_idx_o); else pass_cnt++;
    endtask

    task automatic test_retry();
        init_done_i = 1'b0; w_yumi_i = 1'b0;
        set_rec(1'b1, 9'h040); step();
        set_rec(1'b1, 9'h041); step();
        set_rec(1'b0, 9'h0);
        init_done_i = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            #1;
            total_cnt++; if (w_force_o !== 1'b0) $display("FAIL retry_cycle%0d got %b want 0", c, w_force_o); else pass_cnt++;
            step();
        end
        #1;
        total_cnt++; if (w_force_o !== 1'b1 || w_idx_o !== 9'h040) $display("FAIL retry_cycle4 got force=%b idx=%h want force=1 idx=040", w_force_o, w_idx_o); else pass_cnt++;
        w_yumi_i = 1'b1;
        step();
        w_yumi_i = 1'b0;
        #1;
        total_cnt++; if (w_force_o !== 1'b0 || w_idx_o !== 9'h041) $display("FAIL retry_after got force=%b idx=%h want force=0 idx=041", w_force_o, w_idx_o); else pass_cnt++;
        total_cnt++; if (dut.retry_q !== '0) $display("FAIL retry_cnt_next got %0d want 0", dut.retry_q); else pass_cnt++;
        w_yumi_i = 1'b1;
        step();
        w_yumi_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        init_done_i = 1'b1; w_yumi_i = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            set_rec(1'b1, 9'(9'h050 + i));
            exp_q.push_back(9'(9'h050 + i));
            step();
        end
        for (int i = 0; i < 10; i++) begin
            set_rec(1'b1, 9'(9'h060 + i));
            w_yumi_i = 1'b1;
            exp_q.push_back(9'(9'h060 + i));
            #1;
            total_cnt++; if (w_v_o !== 1'b1 || w_idx_o !== exp_q[0]) $display("FAIL b2b_out%0d got v=%b idx=%h want v=1 idx=%h", i, w_v_o, w_idx_o, exp_q[0]); else pass_cnt++;
            void'(exp_q.pop_front());
            step();
            total_cnt++; if (dut.cnt_q !== 3'd2) $display("FAIL b2b_occ%0d got %0d want 2", i, dut.cnt_q); else pass_cnt++;
        end
        set_rec(1'b0, 9'h0);
        for (int i = 0; i < 2; i++) begin
            #1;
            total_cnt++; if (w_idx_o !== exp_q[0]) $display("FAIL b2b_drain%0d got %h want %h", i, w_idx_o, exp_q[0]); else pass_cnt++;
            void'(exp_q.pop_front());
            step();
        end
        w_yumi_i = 1'b0;
    endtask

    task automatic test_wrap();
        int sent = 0;
        int recv = 0;
        init_done_i = 1'b1; w_yumi_i = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 200 && recv < 9; c++) begin
            set_rec(sent < 9 && $urandom_range(0, 3) != 0, 9'(9'h100 + sent));
            #1;
            w_yumi_i = w_v_o && ($urandom_range(0, 2) != 0);
            if (w_yumi_i) begin
                total_cnt++;
                if (exp_q.size() == 0) $display("FAIL wrap_extra got idx=%h want none", w_idx_o);
                else if (w_idx_o !== exp_q[0]) $display("FAIL wrap_order%0d got %h want %h", recv, w_idx_o, exp_q[0]);
                else pass_cnt++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                recv++;
            end
            if (resolve_v_i && resolve_ready_o) begin
                exp_q.push_back(resolve_idx_i);
                sent++;
            end
            step();
        end
        set_rec(1'b0, 9'h0);
        w_yumi_i = 1'b0;
        #1;
        total_cnt++; if (recv != 9) $display("FAIL wrap_count got %0d want 9", recv); else pass_cnt++;
        total_cnt++; if (w_v_o !== 1'b0) $display("FAIL wrap_empty got %b want 0", w_v_o); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        init_done_i = 1'b0; w_yumi_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_rec(1'b1, 9'(9'h070 + i));
            step();
        end
        set_rec(1'b0, 9'h0);
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        init_done_i = 1'b1;
        #1;
        total_cnt++; if (w_v_o !== 1'b0) $display("FAIL rstmid_w_v got %b want 0", w_v_o); else pass_cnt++;
        total_cnt++; if (resolve_ready_o !== 1'b1) $display("FAIL rstmid_ready got %b want 1", resolve_ready_o); else pass_cnt++;
        for (int c = 0; c < 3; c++) begin
            step();
            total_cnt++; if (w_v_o !== 1'b0) $display("FAIL rstmid_stale%0d got v=%b idx=%h want v=0", c, w_v_o, w_idx_o); else pass_cnt++;
        end
        set_rec(1'b1, 9'h080);
        step();
        set_rec(1'b0, 9'h0);
        #1;
        total_cnt++; if (w_v_o !== 1'b1 || w_idx_o !== 9'h080) $display("FAIL rstmid_new got v=%b idx=%h want v=1 idx=080", w_v_o, w_idx_o); else pass_cnt++;
        w_yumi_i = 1'b1;
        step();
        w_yumi_i = 1'b0;
        #1;
        total_cnt++; if (w_v_o !== 1'b0) $display("FAIL rstmid_drained got %b want 0", w_v_o); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_wait_init();
        test_full();
        test_retry();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
